video_timing_gen: RTL and testbench

//  Raster timing source upstream of the TMDS encode/serialise stage. It generates hsync, vsync and de,

---
 rtl/video_timing_pkg.sv | 36 +++
 rtl/vtg_delay_pipe.sv | 41 ++++
 rtl/video_timing_gen.sv | 129 ++++++++++++
 tb/tb_video_timing_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared mode constants and raster-size helpers for the video timing generator.
package video_timing_pkg;

    // 1280x720p60
    localparam int unsigned P720_H_ACTIVE = 1280;
    localparam int unsigned P720_H_FP     = 110;
    localparam int unsigned P720_H_SYNC   = 40;
    localparam int unsigned P720_H_BP     = 220;
    localparam int unsigned P720_V_ACTIVE = 720;
    localparam int unsigned P720_V_FP     = 5;
    localparam int unsigned P720_V_SYNC   = 5;
    localparam int unsigned P720_V_BP     = 20;
    localparam bit          P720_SYNC_POL = 1'b1;

    // 640x480p60
    localparam int unsigned P480_H_ACTIVE = 640;
    localparam int unsigned P480_H_FP     = 16;
    localparam int unsigned P480_H_SYNC   = 96;
    localparam int unsigned P480_H_BP     = 48;
    localparam int unsigned P480_V_ACTIVE = 480;
    localparam int unsigned P480_V_FP     = 10;
    localparam int unsigned P480_V_SYNC   = 2;
    localparam int unsigned P480_V_BP     = 33;
    localparam bit          P480_SYNC_POL = 1'b0;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_delay_pipe.sv
// DEPTH-stage shift of {de,hs,vs}; de_pre is the stage one before the output, used to
// qualify the pixel-data capture. DEPTH must be at least 2.
module vtg_delay_pipe
    import video_timing_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          IDLE_SYNC = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic de_a,
    input  logic hs_a,
    input  logic vs_a,
    output logic de_pre,
    output logic de_dly,
    output logic hs_dly,
    output logic vs_dly
);

    logic [DEPTH-1:0] de_q;
    logic [DEPTH-1:0] hs_q;
    logic [DEPTH-1:0] vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= '0;
            hs_q <= {DEPTH{IDLE_SYNC}};
            vs_q <= {DEPTH{IDLE_SYNC}};
        end else begin
            de_q <= {de_q[DEPTH-2:0], de_a};
            hs_q <= {hs_q[DEPTH-2:0], hs_a};
            vs_q <= {vs_q[DEPTH-2:0], vs_a};
        end
    end

    assign de_pre = de_q[DEPTH-2];
    assign de_dly = de_q[DEPTH-1];
    assign hs_dly = hs_q[DEPTH-1];
    assign vs_dly = vs_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: coordinate counters and registered request stage, with sync/de and
// returned RGB aligned PIX_LAT+1 clocks after each pixel request.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = P720_H_ACTIVE,
    parameter int unsigned H_FP     = P720_H_FP,
    parameter int unsigned H_SYNC   = P720_H_SYNC,
    parameter int unsigned H_BP     = P720_H_BP,
    parameter int unsigned V_ACTIVE = P720_V_ACTIVE,
    parameter int unsigned V_FP     = P720_V_FP,
    parameter int unsigned V_SYNC   = P720_V_SYNC,
    parameter int unsigned V_BP     = P720_V_BP,
    parameter bit          SYNC_POL = P720_SYNC_POL,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [23:0]      pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [7:0]       rgb_red,
    output logic [7:0]       rgb_green,
    output logic [7:0]       rgb_blue
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_pix_lat
        $error("video_timing_gen: PIX_LAT must be in 1..4");
    end
    if (H_TOTAL >= 2 ** CNT_W || V_TOTAL >= 2 ** CNT_W) begin : g_bad_cnt_w
        $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_a;
    logic             vs_a;
    logic             de_pre;

    // Parking at the last position makes the first enabled clock land on (0,0).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (!en) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            hs_a        <= ~SYNC_POL;
            vs_a        <= ~SYNC_POL;
        end else if (en) begin
            pix_req     <= active;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (active) begin
                req_x <= h_cnt;
                req_y <= v_cnt;
            end
            hs_a <= (h_cnt >= H_SYNC_BEG && h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vs_a <= (v_cnt >= V_SYNC_BEG && v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        end else begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            hs_a        <= ~SYNC_POL;
            vs_a        <= ~SYNC_POL;
        end
    end

    vtg_delay_pipe #(
        .DEPTH     (PIX_LAT + 1),
        .IDLE_SYNC (~SYNC_POL)
    ) u_delay_pipe (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .de_a   (pix_req),
        .hs_a   (hs_a),
        .vs_a   (vs_a),
        .de_pre (de_pre),
        .de_dly (de),
        .hs_dly (hsync),
        .vs_dly (vsync)
    );

    // Capture on the clock where the delayed request meets its returned data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {rgb_red, rgb_green, rgb_blue} <= '0;
        end else if (de_pre) begin
            {rgb_red, rgb_green, rgb_blue} <= pix_data;
        end else begin
            {rgb_red, rgb_green, rgb_blue} <= '0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a raster model checked every cycle against two instances
// (positive sync / latency 1 and negative sync / latency 3), plus hand-computed timing points.
module tb_video_timing_gen;

    localparam int HT    = 15;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int NS    = 260;

    typedef struct packed {
        logic        req;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
    } sa_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] pd_a;
    logic [23:0] pd_b;

    logic        req_a, fs_a, hs_a, vs_a, de_a;
    logic [11:0] x_a, y_a;
    logic [7:0]  r_a, g_a, b_a;
    logic        req_b, fs_b, hs_b, vs_b, de_b;
    logic [11:0] x_b, y_b;
    logic [7:0]  r_b, g_b, b_b;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .PIX_LAT(LAT_A), .CNT_W(12)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .pix_data(pd_a),
        .pix_req(req_a), .req_x(x_a), .req_y(y_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .rgb_red(r_a), .rgb_green(g_a), .rgb_blue(b_a)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIX_LAT(LAT_B), .CNT_W(12)
    ) dut_neg (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .pix_data(pd_b),
        .pix_req(req_b), .req_x(x_b), .req_y(y_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .rgb_red(r_b), .rgb_green(g_b), .rgb_blue(b_b)
    );

    // Raster model: k is the linear counter position; hist[j] is the request-stage
    // record produced j edges ago, so aligned outputs read hist[LAT+1].
    sa_t         hist [0:7];
    int          k;
    logic [11:0] mx, my;

    task automatic model_reset();
        sa_t s;
        s = '0;
        k = FRAME - 1;
        mx = '0;
        my = '0;
        for (int i = 0; i < 8; i++) hist[i] = s;
    endtask

    task automatic model_step();
        sa_t s;
        int h, v;
        h = k % HT;
        v = k / HT;
        s = '0;
        if (en) begin
            s.req = (h < 8) && (v < 4);
            s.fs  = (h == 0) && (v == 0);
            if (s.req) begin
                mx = 12'(h);
                my = 12'(v);
            end
            s.hs = (h >= 10) && (h < 13);
            s.vs = (v >= 5) && (v < 7);
            k = (k + 1) % FRAME;
        end else begin
            k = FRAME - 1;
        end
        s.x = mx;
        s.y = my;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        sa_t sa, sb;
        sa = hist[LAT_A + 1];
        sb = hist[LAT_B + 1];
        check("a.pix_req", 32'(req_a), 32'(hist[0].req));
        check("a.frame_start", 32'(fs_a), 32'(hist[0].fs));
        check("a.req_x", 32'(x_a), 32'(hist[0].x));
        check("a.req_y", 32'(y_a), 32'(hist[0].y));
        check("a.hsync", 32'(hs_a), 32'(sa.hs));
        check("a.vsync", 32'(vs_a), 32'(sa.vs));
        check("a.de", 32'(de_a), 32'(sa.req));
        check("a.rgb", 32'({r_a, g_a, b_a}),
              sa.req ? 32'({sa.x[7:0], sa.y[7:0], 8'hA5}) : 32'd0);
        check("b.pix_req", 32'(req_b), 32'(hist[0].req));
        check("b.frame_start", 32'(fs_b), 32'(hist[0].fs));
        check("b.req_x", 32'(x_b), 32'(hist[0].x));
        check("b.req_y", 32'(y_b), 32'(hist[0].y));
        check("b.hsync", 32'(hs_b), 32'(!sb.hs));
        check("b.vsync", 32'(vs_b), 32'(!sb.vs));
        check("b.de", 32'(de_b), 32'(sb.req));
        check("b.rgb", 32'({r_b, g_b, b_b}),
              sb.req ? 32'({sb.x[7:0], sb.y[7:0], 8'hA5}) : 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) compare_all();
        end
    end

    // Pixel source: answers each request PIX_LAT clocks later, random junk otherwise.
    logic        qa_req [0:3];
    logic [11:0] qa_x [0:3];
    logic [11:0] qa_y [0:3];
    logic        qb_req [0:3];
    logic [11:0] qb_x [0:3];
    logic [11:0] qb_y [0:3];

    initial begin
        for (int i = 0; i < 4; i++) begin
            qa_req[i] = 1'b0; qa_x[i] = '0; qa_y[i] = '0;
            qb_req[i] = 1'b0; qb_x[i] = '0; qb_y[i] = '0;
        end
        pd_a = '0;
        pd_b = '0;
        forever begin
            @(negedge clk);
            pd_a = qa_req[LAT_A-1] ? {qa_x[LAT_A-1][7:0], qa_y[LAT_A-1][7:0], 8'hA5}
                                   : 24'($urandom);
            pd_b = qb_req[LAT_B-1] ? {qb_x[LAT_B-1][7:0], qb_y[LAT_B-1][7:0], 8'hA5}
                                   : 24'($urandom);
            for (int i = 3; i > 0; i--) begin
                qa_req[i] = qa_req[i-1]; qa_x[i] = qa_x[i-1]; qa_y[i] = qa_y[i-1];
                qb_req[i] = qb_req[i-1]; qb_x[i] = qb_x[i-1]; qb_y[i] = qb_y[i-1];
            end
            qa_req[0] = req_a; qa_x[0] = x_a; qa_y[0] = y_a;
            qb_req[0] = req_b; qb_x[0] = x_b; qb_y[0] = y_b;
        end
    end

    function automatic int first_one(input bit [NS-1:0] v, input int from);
        for (int i = (from < 0 ? 0 : from); i < NS; i++) if (v[i]) return i;
        return -1000;
    endfunction

    function automatic int count_ones(input bit [NS-1:0] v, input int from, input int len);
        int n = 0;
        for (int i = from; i < from + len; i++) if (i >= 0 && i < NS && v[i]) n++;
        return n;
    endfunction

    // Expects rst_n just released at a negedge with en=1.
    task automatic measure_frame(input string tag);
        bit [NS-1:0] s_req, s_fs, s_hs, s_vs, s_de, s_deb, s_hsb_n;
        int rf, df, dfb, hf;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            s_req[i] = req_a; s_fs[i] = fs_a; s_hs[i] = hs_a; s_vs[i] = vs_a;
            s_de[i] = de_a; s_deb[i] = de_b; s_hsb_n[i] = !hs_b;
        end
        rf  = first_one(s_req, 0);
        check({tag, ".first_req"}, 32'(rf), 32'd1);
        if (rf < 0) rf = 0;
        df  = first_one(s_de, 0);
        dfb = first_one(s_deb, 0);
        hf  = first_one(s_hs, 0);
        check({tag, ".fs_at_first_req"}, 32'(s_fs[rf]), 32'd1);
        check({tag, ".fs_next_frame"}, 32'(s_fs[rf + FRAME]), 32'd1);
        check({tag, ".fs_per_frame"}, 32'(count_ones(s_fs, rf, FRAME)), 32'd1);
        check({tag, ".req_per_line"}, 32'(count_ones(s_req, rf, HT)), 32'd8);
        check({tag, ".req_per_frame"}, 32'(count_ones(s_req, rf, FRAME)), 32'd32);
        check({tag, ".de_latency"}, 32'(df - rf), 32'd2);
        check({tag, ".de_b_latency"}, 32'(dfb - rf), 32'd4);
        check({tag, ".de_per_frame"}, 32'(count_ones(s_de, rf + 2, FRAME)), 32'd32);
        check({tag, ".hsync_offset"}, 32'(hf - df), 32'd10);
        check({tag, ".hsync_width"}, 32'(count_ones(s_hs, hf, HT)), 32'd3);
        check({tag, ".hsync_per_frame"}, 32'(count_ones(s_hs, rf + 2, FRAME)), 32'd24);
        check({tag, ".hsync_b_offset"}, 32'(first_one(s_hsb_n, 0) - dfb), 32'd10);
        check({tag, ".vsync_offset"}, 32'(first_one(s_vs, 0) - df), 32'd75);
        check({tag, ".vsync_width"}, 32'(count_ones(s_vs, rf + 2, FRAME)), 32'd30);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, nde_a, nde_b, wait_n;
        logic [7:0] lr, lg;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        check("reset.hsync_a", 32'(hs_a), 32'd0);
        check("reset.hsync_b", 32'(hs_b), 32'd1);
        check("reset.req_x", 32'(x_a), 32'd0);

        // Free-running timing from reset release.
        rst_n = 1'b1;
        measure_frame("t1");

        // Enable drop at request (3,2).
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (req_a && x_a == 12'd3 && y_a == 12'd2) found = 1;
        end
        check("en.found_3_2", 32'(found), 32'd1);
        en = 1'b0;
        nde_a = 0; nde_b = 0; lr = '0; lg = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (de_a) begin
                nde_a++;
                lr = r_a;
                lg = g_a;
            end
            if (de_b) nde_b++;
        end
        check("en.drain_a", 32'(nde_a), 32'd2);
        check("en.drain_b", 32'(nde_b), 32'd4);
        check("en.last_red", 32'(lr), 32'd3);
        check("en.last_green", 32'(lg), 32'd2);
        check("en.idle_de", 32'(de_a), 32'd0);
        check("en.idle_hsync", 32'(hs_a), 32'd0);
        check("en.idle_vsync", 32'(vs_a), 32'd0);
        check("en.idle_hsync_b", 32'(hs_b), 32'd1);
        en = 1'b1;
        wait_n = -1;
        for (int i = 1; i <= 10 && wait_n < 0; i++) begin
            @(negedge clk);
            if (req_a) wait_n = i;
        end
        check("en.restart_delay", 32'(wait_n), 32'd2);
        check("en.restart_fs", 32'(fs_a), 32'd1);
        check("en.restart_xy", 32'({x_a, y_a}), 32'd0);

        // Asynchronous reset while de is high.
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (de_a) found = 1;
        end
        check("rst.found_de", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare_all();
        check("rst.de", 32'(de_a), 32'd0);
        check("rst.rgb", 32'({r_a, g_a, b_a}), 32'd0);
        check("rst.pix_req", 32'(req_a), 32'd0);
        check("rst.hsync_b", 32'(hs_b), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure_frame("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
